// File: rtl/data_cache_arbiter_if.sv
// Requester-side bundle of the data cache arbiter: packed request lanes plus the shared response bus.
interface data_cache_arbiter_if #(
    parameter int NUM_REQ          = 4,
    parameter int DATA_CACHE_WIDTH = 16,
    parameter int ADDR_W           = 12
);
    logic [NUM_REQ-1:0]                  req_valid_in;
    logic [NUM_REQ-1:0]                  req_we_in;
    logic [NUM_REQ*ADDR_W-1:0]           req_addr_in;
    logic [NUM_REQ*DATA_CACHE_WIDTH-1:0] req_data_in;
    logic [NUM_REQ-1:0]                  req_ready_out;
    logic [NUM_REQ-1:0]                  rsp_valid_out;
    logic [DATA_CACHE_WIDTH-1:0]         rsp_data_out;
    logic                                rsp_err_out;

    modport master (
        output req_valid_in, req_we_in, req_addr_in, req_data_in,
        input  req_ready_out, rsp_valid_out, rsp_data_out, rsp_err_out
    );

    modport slave (
        input  req_valid_in, req_we_in, req_addr_in, req_data_in,
        output req_ready_out, rsp_valid_out, rsp_data_out, rsp_err_out
    );
endinterface

// File: rtl/data_cache_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one BRAM port, with a tag
// pipeline that routes each read response back to its requester after READ_LATENCY.
module data_cache_arbiter #(
    parameter int  NUM_REQ          = 4,
    parameter int  DATA_CACHE_WIDTH = 16,
    parameter int  DATA_CACHE_DEPTH = 4000,
    parameter int  READ_LATENCY     = 2,
    localparam int ADDR_W           = $clog2(DATA_CACHE_DEPTH),
    localparam int IDX_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    data_cache_arbiter_if.slave         bus,
    output logic                        mem_en_out,
    output logic                        mem_we_out,
    output logic [ADDR_W-1:0]           mem_addr_out,
    output logic [DATA_CACHE_WIDTH-1:0] mem_din_out,
    input  logic [DATA_CACHE_WIDTH-1:0] mem_dout_in,
    output logic                        busy_out
);
    localparam logic [ADDR_W:0]    DEPTH_C    = (ADDR_W+1)'(DATA_CACHE_DEPTH);
    localparam logic [IDX_W:0]     NUM_REQ_C  = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_IDX_C = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]            ptr_r;
    logic                        in_reset_r;
    logic [IDX_W-1:0]            grant_idx_s;
    logic                        grant_found_s;
    logic                        accept_s;
    logic [IDX_W-1:0]            ptr_next_s;
    logic [ADDR_W-1:0]           sel_addr_s;
    logic [DATA_CACHE_WIDTH-1:0] sel_data_s;
    logic                        sel_we_s;
    logic                        sel_oor_s;
    logic [READ_LATENCY:0]       tag_valid_r;
    logic [READ_LATENCY:0]       tag_err_r;
    logic [IDX_W-1:0]            tag_idx_r [READ_LATENCY+1];

    // Round-robin scan from ptr_r; grants are suppressed during reset and the cycle after it.
    always_comb begin
        logic [IDX_W:0]   sum_v;
        logic [IDX_W-1:0] cand_v;
        logic             hit_v;
        grant_found_s = 1'b0;
        grant_idx_s   = ptr_r;
        sum_v         = '0;
        cand_v        = '0;
        hit_v         = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_v         = {1'b0, ptr_r} + (IDX_W+1)'(i);
            cand_v        = (sum_v >= NUM_REQ_C) ? IDX_W'(sum_v - NUM_REQ_C) : sum_v[IDX_W-1:0];
            hit_v         = bus.req_valid_in[cand_v] & ~grant_found_s;
            grant_idx_s   = hit_v ? cand_v : grant_idx_s;
            grant_found_s = grant_found_s | hit_v;
        end
        accept_s   = grant_found_s & ~rst_in & ~in_reset_r;
        ptr_next_s = (grant_idx_s == LAST_IDX_C) ? '0 : grant_idx_s + IDX_W'(1);
    end

    // Grant strobe plus mux of the granted requester's command fields.
    always_comb begin
        bus.req_ready_out = '0;
        sel_addr_s        = '0;
        sel_data_s        = '0;
        sel_we_s          = bus.req_we_in[grant_idx_s];
        if (accept_s) begin
            bus.req_ready_out[grant_idx_s] = 1'b1;
        end else begin
            bus.req_ready_out = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s = (grant_idx_s == IDX_W'(i)) ? bus.req_addr_in[i*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_data_s = (grant_idx_s == IDX_W'(i)) ?
                         bus.req_data_in[i*DATA_CACHE_WIDTH +: DATA_CACHE_WIDTH] : sel_data_s;
        end
        sel_oor_s = ({1'b0, sel_addr_s} >= DEPTH_C);
    end

    // Priority pointer and the one-cycle post-reset grant blanking flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_r      <= '0;
            in_reset_r <= 1'b1;
        end else begin
            in_reset_r <= 1'b0;
            if (accept_s) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    // Registered BRAM command; out-of-range accesses never enable the port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_en_out   <= 1'b0;
            mem_we_out   <= 1'b0;
            mem_addr_out <= '0;
            mem_din_out  <= '0;
        end else if (accept_s) begin
            mem_en_out   <= ~sel_oor_s;
            mem_we_out   <= sel_we_s & ~sel_oor_s;
            mem_addr_out <= sel_addr_s;
            mem_din_out  <= sel_data_s;
        end else begin
            mem_en_out   <= 1'b0;
            mem_we_out   <= 1'b0;
        end
    end

    // Read tag pipeline: stage k is visible k+1 cycles after acceptance.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_valid_r <= '0;
            tag_err_r   <= '0;
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tag_idx_r[k] <= '0;
            end
        end else begin
            tag_valid_r[0] <= accept_s & ~sel_we_s;
            tag_err_r[0]   <= sel_oor_s;
            tag_idx_r[0]   <= grant_idx_s;
            for (int k = 1; k <= READ_LATENCY; k++) begin
                tag_valid_r[k] <= tag_valid_r[k-1];
                tag_err_r[k]   <= tag_err_r[k-1];
                tag_idx_r[k]   <= tag_idx_r[k-1];
            end
        end
    end

    // Response routing; BRAM data passes through in the cycle it is valid.
    always_comb begin
        bus.rsp_valid_out = '0;
        bus.rsp_data_out  = '0;
        bus.rsp_err_out   = 1'b0;
        busy_out          = ~rst_in & (|tag_valid_r);
        if (!rst_in && tag_valid_r[READ_LATENCY]) begin
            bus.rsp_valid_out[tag_idx_r[READ_LATENCY]] = 1'b1;
            bus.rsp_err_out  = tag_err_r[READ_LATENCY];
            bus.rsp_data_out = tag_err_r[READ_LATENCY] ? '0 : mem_dout_in;
        end else begin
            bus.rsp_valid_out = '0;
        end
    end
endmodule

// File: tb/tb_data_cache_arbiter.sv
// Directed bench for data_cache_arbiter: cycle-by-cycle vector table plus hand sequences
// for fairness and mid-flight reset, against a read-first 2-cycle BRAM model.
module tb_data_cache_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    always #5 clk_in = ~clk_in;

    data_cache_arbiter_if #(.NUM_REQ(NR), .DATA_CACHE_WIDTH(DW), .ADDR_W(AW)) bus ();

    data_cache_arbiter #(
        .NUM_REQ(NR), .DATA_CACHE_WIDTH(DW), .DATA_CACHE_DEPTH(4000), .READ_LATENCY(2)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus),
        .mem_en_out   (mem_en),
        .mem_we_out   (mem_we),
        .mem_addr_out (mem_addr),
        .mem_din_out  (mem_din),
        .mem_dout_in  (mem_dout),
        .busy_out     (busy)
    );

    function automatic logic [15:0] pat(input logic [11:0] a);
        return 16'hA5A5 ^ {4'h0, a};
    endfunction

    // BRAM model: read-first, data valid two edges after the address-sampling edge.
    logic [15:0] ram [4096];
    logic [15:0] rd1, rd2;
    always @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 4096; i++) ram[i] <= pat(12'(i));
        end else if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_din;
        end
        if (mem_en) rd1 <= ram[mem_addr];
        rd2 <= rd1;
    end
    assign mem_dout = rd2;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  we;
        logic [47:0] addr;
        logic [63:0] data;
        logic [3:0]  rdy;
        logic        en;
        logic        mwe;
        logic [11:0] maddr;
        logic [15:0] mdin;
        logic [3:0]  rv;
        logic [15:0] rd;
        logic        err;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] we,
                                input logic [47:0] addr, input logic [63:0] data,
                                input logic [3:0] rdy, input logic en, input logic mwe,
                                input logic [11:0] maddr, input logic [15:0] mdin,
                                input logic [3:0] rv, input logic [15:0] rd,
                                input logic err, input logic bsy);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.data = data;
        v.rdy = rdy; v.en = en; v.mwe = mwe; v.maddr = maddr; v.mdin = mdin;
        v.rv = rv; v.rd = rd; v.err = err; v.busy = bsy;
        return v;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] we,
                         input logic [47:0] a, input logic [63:0] d);
        bus.req_valid_in = v;
        bus.req_we_in    = we;
        bus.req_addr_in  = a;
        bus.req_data_in  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    localparam logic [47:0] A_ADDR = {12'd13, 12'd12, 12'd11, 12'd10};
    localparam logic [47:0] B_ADDR = {12'd0, 12'd100, 24'd0};
    localparam logic [63:0] B_DATA = {16'h0, 16'hBEEF, 32'h0};
    localparam logic [47:0] C_ADDR = {24'd0, 12'd4000, 12'd0};
    localparam logic [47:0] D_ADDR = {36'd0, 12'd4095};
    localparam logic [63:0] D_DATA = {48'h0, 16'h1234};

    vec_t tbl [22];

    initial begin
        int g0, g3, w0, w3, mw0, mw3;
        // all four read 10..13 for 8 grants, then drain the responses
        tbl[0]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b0001, 1'b0, 1'b0, 12'd0,   16'h0, 4'b0000, 16'h0,    1'b0, 1'b0);
        tbl[1]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b0010, 1'b1, 1'b0, 12'd10,  16'h0, 4'b0000, 16'h0,    1'b0, 1'b1);
        tbl[2]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b0100, 1'b1, 1'b0, 12'd11,  16'h0, 4'b0000, 16'h0,    1'b0, 1'b1);
        tbl[3]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b1000, 1'b1, 1'b0, 12'd12,  16'h0, 4'b0001, pat(10),  1'b0, 1'b1);
        tbl[4]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b0001, 1'b1, 1'b0, 12'd13,  16'h0, 4'b0010, pat(11),  1'b0, 1'b1);
        tbl[5]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b0010, 1'b1, 1'b0, 12'd10,  16'h0, 4'b0100, pat(12),  1'b0, 1'b1);
        tbl[6]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b0100, 1'b1, 1'b0, 12'd11,  16'h0, 4'b1000, pat(13),  1'b0, 1'b1);
        tbl[7]  = mk(4'hF, 4'h0, A_ADDR, 64'h0, 4'b1000, 1'b1, 1'b0, 12'd12,  16'h0, 4'b0001, pat(10),  1'b0, 1'b1);
        tbl[8]  = mk(4'h0, 4'h0, A_ADDR, 64'h0, 4'b0000, 1'b1, 1'b0, 12'd13,  16'h0, 4'b0010, pat(11),  1'b0, 1'b1);
        tbl[9]  = mk(4'h0, 4'h0, A_ADDR, 64'h0, 4'b0000, 1'b0, 1'b0, 12'd0,   16'h0, 4'b0100, pat(12),  1'b0, 1'b1);
        tbl[10] = mk(4'h0, 4'h0, A_ADDR, 64'h0, 4'b0000, 1'b0, 1'b0, 12'd0,   16'h0, 4'b1000, pat(13),  1'b0, 1'b1);
        tbl[11] = mk(4'h0, 4'h0, A_ADDR, 64'h0, 4'b0000, 1'b0, 1'b0, 12'd0,   16'h0, 4'b0000, 16'h0,    1'b0, 1'b0);
        // req2 write-then-read of addr 100, req1 out-of-range read, req0 out-of-range write
        tbl[12] = mk(4'b0100, 4'b0100, B_ADDR, B_DATA, 4'b0100, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0000, 16'h0,    1'b0, 1'b0);
        tbl[13] = mk(4'b0100, 4'b0000, B_ADDR, B_DATA, 4'b0100, 1'b1, 1'b1, 12'd100, 16'hBEEF, 4'b0000, 16'h0,    1'b0, 1'b0);
        tbl[14] = mk(4'b0010, 4'b0000, C_ADDR, 64'h0,  4'b0010, 1'b1, 1'b0, 12'd100, 16'h0,    4'b0000, 16'h0,    1'b0, 1'b1);
        tbl[15] = mk(4'b0000, 4'b0000, C_ADDR, 64'h0,  4'b0000, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0000, 16'h0,    1'b0, 1'b1);
        tbl[16] = mk(4'b0000, 4'b0000, C_ADDR, 64'h0,  4'b0000, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0100, 16'hBEEF, 1'b0, 1'b1);
        tbl[17] = mk(4'b0000, 4'b0000, C_ADDR, 64'h0,  4'b0000, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0010, 16'h0,    1'b1, 1'b1);
        tbl[18] = mk(4'b0001, 4'b0001, D_ADDR, D_DATA, 4'b0001, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0000, 16'h0,    1'b0, 1'b0);
        tbl[19] = mk(4'b0000, 4'b0000, D_ADDR, 64'h0,  4'b0000, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0000, 16'h0,    1'b0, 1'b0);
        tbl[20] = mk(4'b0000, 4'b0000, D_ADDR, 64'h0,  4'b0000, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0000, 16'h0,    1'b0, 1'b0);
        tbl[21] = mk(4'b0000, 4'b0000, D_ADDR, 64'h0,  4'b0000, 1'b0, 1'b0, 12'd0,   16'h0,    4'b0000, 16'h0,    1'b0, 1'b0);

        rst_in = 1'b1;
        drive(4'hF, 4'h0, A_ADDR, 64'h0);
        repeat (3) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        chk("reset ready", bus.req_ready_out, 4'b0000);
        chk("reset mem_en", mem_en, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset mem_addr", mem_addr, 12'd0);
        chk("reset mem_din", mem_din, 16'h0);
        chk("reset rsp_valid", bus.rsp_valid_out, 4'b0000);
        chk("reset rsp_data", bus.rsp_data_out, 16'h0);
        chk("reset rsp_err", bus.rsp_err_out, 1'b0);
        chk("reset busy", busy, 1'b0);
        next_cycle();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("post-reset ready", bus.req_ready_out, 4'b0000);
        chk("post-reset rsp_valid", bus.rsp_valid_out, 4'b0000);
        chk("post-reset busy", busy, 1'b0);
        next_cycle();

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].data);
            @(negedge clk_in);
            chk($sformatf("row%0d ready", i), bus.req_ready_out, tbl[i].rdy);
            chk($sformatf("row%0d mem_en", i), mem_en, tbl[i].en);
            chk($sformatf("row%0d mem_we", i), mem_we, tbl[i].mwe);
            if (tbl[i].en) chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].maddr);
            if (tbl[i].mwe) chk($sformatf("row%0d mem_din", i), mem_din, tbl[i].mdin);
            chk($sformatf("row%0d rsp_valid", i), bus.rsp_valid_out, tbl[i].rv);
            chk($sformatf("row%0d rsp_data", i), bus.rsp_data_out, tbl[i].rd);
            chk($sformatf("row%0d rsp_err", i), bus.rsp_err_out, tbl[i].err);
            chk($sformatf("row%0d busy", i), busy, tbl[i].busy);
            next_cycle();
        end

        // fairness: req3 alone, then req0 joins and both are held for 100 cycles
        drive(4'b1000, 4'b1000, {12'd512, 36'd0}, {16'h5555, 48'h0});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            chk("rr solo req3", bus.req_ready_out, 4'b1000);
            next_cycle();
        end
        drive(4'b1001, 4'b1001, {12'd512, 24'd0, 12'd513}, {16'h5555, 32'h0, 16'h6666});
        g0 = 0; g3 = 0; w0 = 0; w3 = 0; mw0 = 0; mw3 = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_in);
            if (c == 0) chk("rr req0 first grant", bus.req_ready_out, 4'b0001);
            chk("rr onehot", 32'($countones(bus.req_ready_out)), 32'd1);
            if (bus.req_ready_out[0]) begin g0++; w0 = 0; end
            else begin w0++; mw0 = (w0 > mw0) ? w0 : mw0; end
            if (bus.req_ready_out[3]) begin g3++; w3 = 0; end
            else begin w3++; mw3 = (w3 > mw3) ? w3 : mw3; end
            next_cycle();
        end
        chk("rr grants req0", 32'(g0), 32'd50);
        chk("rr grants req3", 32'(g3), 32'd50);
        chk("rr max wait req0", 32'(mw0), 32'd1);
        chk("rr max wait req3", 32'(mw3), 32'd1);
        drive(4'h0, 4'h0, 48'h0, 64'h0);
        repeat (4) next_cycle();

        // reads accepted in T and T+1, reset in T+2
        drive(4'b0001, 4'b0000, {36'd0, 12'd20}, 64'h0);
        @(negedge clk_in);
        chk("flush T ready", bus.req_ready_out, 4'b0001);
        next_cycle();
        drive(4'b0010, 4'b0000, {24'd0, 12'd21, 12'd0}, 64'h0);
        @(negedge clk_in);
        chk("flush T+1 ready", bus.req_ready_out, 4'b0010);
        next_cycle();
        rst_in = 1'b1;
        drive(4'h0, 4'h0, 48'h0, 64'h0);
        @(negedge clk_in);
        chk("flush T+2 rsp_valid", bus.rsp_valid_out, 4'b0000);
        chk("flush T+2 busy", busy, 1'b0);
        chk("flush T+2 ready", bus.req_ready_out, 4'b0000);
        next_cycle();
        rst_in = 1'b0;
        drive(4'hF, 4'hF, {12'd303, 12'd302, 12'd301, 12'd300},
              {16'h4444, 16'h3333, 16'h2222, 16'h1111});
        @(negedge clk_in);
        chk("flush T+3 ready", bus.req_ready_out, 4'b0000);
        chk("flush T+3 rsp_valid", bus.rsp_valid_out, 4'b0000);
        chk("flush T+3 busy", busy, 1'b0);
        chk("flush T+3 mem_en", mem_en, 1'b0);
        next_cycle();
        @(negedge clk_in);
        chk("flush T+4 ready ptr0", bus.req_ready_out, 4'b0001);
        chk("flush T+4 rsp_valid", bus.rsp_valid_out, 4'b0000);
        chk("flush T+4 busy", busy, 1'b0);
        chk("flush T+4 mem_en", mem_en, 1'b0);
        next_cycle();
        @(negedge clk_in);
        chk("flush T+5 ready", bus.req_ready_out, 4'b0010);
        chk("flush T+5 rsp_valid", bus.rsp_valid_out, 4'b0000);
        chk("flush T+5 busy", busy, 1'b0);
        chk("flush T+5 mem_en", mem_en, 1'b1);
        chk("flush T+5 mem_we", mem_we, 1'b1);
        chk("flush T+5 mem_addr", mem_addr, 12'd300);
        chk("flush T+5 mem_din", mem_din, 16'h1111);
        next_cycle();
        drive(4'h0, 4'h0, 48'h0, 64'h0);
        repeat (2) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_cache_arbiter.md
DATA_CACHE_ARBITER -- requirements
Module: data_cache_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the data cache.
REQ-002 Parameter DATA_CACHE_WIDTH, default 16, bits per data word.
REQ-003 Parameter DATA_CACHE_DEPTH, default 4000, addressable words.
REQ-004 Parameter READ_LATENCY, default 2, BRAM read latency in cycles from the address-sampling edge.
REQ-005 Localparam ADDR_W = $clog2(DATA_CACHE_DEPTH) (12 at default); IDX_W = $clog2(NUM_REQ).
REQ-006 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_in  input  1  reset, synchronous, active-high.
REQ-008 req_valid_in  input  NUM_REQ  per-requester request valid.
REQ-009 req_we_in  input  NUM_REQ  per-requester write enable (1 = write, 0 = read).
REQ-010 req_addr_in  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
REQ-011 req_data_in  input  NUM_REQ*DATA_CACHE_WIDTH  packed write data, same packing.
REQ-012 req_ready_out  output  NUM_REQ  grant; one-hot or zero.
REQ-013 rsp_valid_out  output  NUM_REQ  read-response strobe; one-hot or zero.
REQ-014 rsp_data_out  output  DATA_CACHE_WIDTH  shared read-response data.
REQ-015 rsp_err_out  output  1  qualifies rsp_valid_out: response was out of range.
REQ-016 mem_en_out, mem_we_out  output  1 each  BRAM port enable / write enable.
REQ-017 mem_addr_out  output  ADDR_W;  mem_din_out  output  DATA_CACHE_WIDTH;  mem_dout_in  input  DATA_CACHE_WIDTH.
REQ-018 busy_out  output  1  high while any read is in flight.

Function
REQ-019 Handshake: request i accepted in a cycle iff req_valid_in[i] && req_ready_out[i]; at most one acceptance per cycle.
REQ-020 req_ready_out combinational from req_valid_in and priority pointer ptr; asserted only for the requester granted.
REQ-021 Round-robin: grant the first valid requester scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
REQ-022 After acceptance from requester g, ptr <= (g+1) mod NUM_REQ; with no acceptance, ptr holds.
REQ-023 Requester may hold valid indefinitely; an unaccepted request waits at most NUM_REQ-1 grants to others (no starvation).
REQ-024 Accepted request in cycle T drives registered mem_en_out=1, mem_we_out, mem_addr_out, mem_din_out during cycle T+1; otherwise mem_en_out=0, mem_we_out=0.
REQ-025 Address >= DATA_CACHE_DEPTH: still accepted; mem_en_out and mem_we_out stay 0 in T+1.
REQ-026 Accepted read in cycle T: rsp_valid_out[g]=1 exactly in cycle T+1+READ_LATENCY, rsp_data_out = mem_dout_in that cycle, rsp_err_out=0.
REQ-027 Out-of-range read: response in the same cycle T+1+READ_LATENCY, rsp_data_out=0, rsp_err_out=1.
REQ-028 Writes (in or out of range) produce no response; out-of-range writes are dropped silently.
REQ-029 Responses tracked in a READ_LATENCY+1 deep tag pipeline (valid, requester index, err); fully pipelined, one response per cycle max, order = acceptance order.
REQ-030 rsp_data_out=0 and rsp_err_out=0 in cycles with no response.
REQ-031 Write then read of the same address in consecutive cycles returns the new data (BRAM read-first on a single port suffices since accesses are serialized).
REQ-032 busy_out = OR of tag-pipeline valid bits.

Reset
REQ-033 While rst_in high: ptr=0, tag pipeline cleared, mem_en_out=0, mem_we_out=0, mem_addr_out=0, mem_din_out=0.
REQ-034 During and the cycle after reset: rsp_valid_out=0, rsp_data_out=0, rsp_err_out=0, busy_out=0, req_ready_out=0.
REQ-035 Reset mid-operation discards in-flight reads; no response is ever issued for them.

Verification
REQ-036 All 4 requesters valid, reads to addr 10,11,12,13, held 8 cycles -> grants in order 0,1,2,3,0,1,2,3; responses on matching rsp_valid_out bit 3 cycles after each grant.
REQ-037 Req 2 writes 0xBEEF to addr 100 in cycle T, req 2 reads addr 100 in T+1 -> rsp_valid_out=4'b0100, rsp_data_out=0xBEEF in cycle T+4.
REQ-038 Req 1 reads addr 4000 -> mem_en_out stays 0; rsp_valid_out[1]=1, rsp_err_out=1, rsp_data_out=0 three cycles after grant.
REQ-039 Only req 3 valid continuously, req 0 becomes valid -> req 0 granted within 1 cycle of next pointer wrap; neither starves over 100 cycles.
REQ-040 Reads accepted in cycles T and T+1, rst_in high in T+2 -> no rsp_valid_out in T+3..T+5; busy_out=0 from T+3; ptr=0 afterwards.
